ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the accumulator datapath (8-bit PC/MAR, 16-bit IR/ACC/MDR).
- Consumes opcode and zflag from the datapath.
- Drives every mux select, register load and ALU op, plus the memory write strobe.
- Implements fetch / decode / memory / execute sequencing, a halt state and a retired-instruction counter.

---
 rtl/ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/decode/memory/execute controller for the accumulator datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the machine and raise illop.
module ctrl_fsm #(
   parameter int unsigned CNT_W  = 16,
   parameter logic [7:0]  HLT_OP = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       opcode,
   input  logic             zflag,
   output logic             muxPC,
   output logic             muxMAR,
   output logic             muxACC,
   output logic             loadMAR,
   output logic             loadPC,
   output logic             loadACC,
   output logic             loadMDR,
   output logic             loadIR,
   output logic [1:0]       opALU,
   output logic             memWE,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic             illop
`endif
);

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_AND = 8'h03;
   localparam logic [7:0] OP_NOT = 8'h04;
   localparam logic [7:0] OP_LDA = 8'h05;
   localparam logic [7:0] OP_STA = 8'h06;
   localparam logic [7:0] OP_JMP = 8'h07;
   localparam logic [7:0] OP_JZ  = 8'h08;

   // 4-bit encoding leaves spare codes; those fall into the default arm and recover to S_IDLE.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH0 = 4'd1,
      S_FETCH1 = 4'd2,
      S_FETCH2 = 4'd3,
      S_DECODE = 4'd4,
      S_MEM    = 4'd5,
      S_EXEC   = 4'd6,
      S_HALT   = 4'd7
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic             illop_q, illop_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illop_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illop_q <= illop_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illop_d = illop_q;
`endif
      muxPC   = 1'b0;
      muxMAR  = 1'b0;
      muxACC  = 1'b0;
      loadMAR = 1'b0;
      loadPC  = 1'b0;
      loadACC = 1'b0;
      loadMDR = 1'b0;
      loadIR  = 1'b0;
      opALU   = 2'b00;
      memWE   = 1'b0;
      halted  = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH0;
         S_FETCH0: begin
            loadMAR = 1'b1;
            state_d = S_FETCH1;
         end
         S_FETCH1: begin
            loadMDR = 1'b1;
            loadPC  = 1'b1;
            state_d = S_FETCH2;
         end
         S_FETCH2: begin
            loadIR  = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_FETCH0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (opcode == HLT_OP) begin
               state_d = S_HALT;
            end else begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_LDA: begin
                     loadMAR = 1'b1;
                     muxMAR  = 1'b1;
                     state_d = S_MEM;
                  end
                  OP_STA: begin
                     loadMAR = 1'b1;
                     muxMAR  = 1'b1;
                     state_d = S_EXEC;
                  end
                  OP_NOT: begin
                     loadACC = 1'b1;
                     opALU   = 2'b11;
                  end
                  OP_JMP: begin
                     loadPC = 1'b1;
                     muxPC  = 1'b1;
                  end
                  OP_JZ: begin
                     loadPC = zflag;
                     muxPC  = 1'b1;
                  end
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     // Trapping instruction is not retired.
                     cnt_d   = cnt_q;
                     illop_d = 1'b1;
                     state_d = S_HALT;
`endif
                  end
               endcase
            end
         end
         S_MEM: begin
            loadMDR = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH0;
            case (opcode)
               OP_ADD: loadACC = 1'b1;
               OP_SUB: begin
                  loadACC = 1'b1;
                  opALU   = 2'b01;
               end
               OP_AND: begin
                  loadACC = 1'b1;
                  opALU   = 2'b10;
               end
               OP_LDA: begin
                  loadACC = 1'b1;
                  muxACC  = 1'b1;
               end
               OP_STA:  memWE = 1'b1;
               default: ;
            endcase
         end
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_count = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illop = illop_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed table-driven bench for ctrl_fsm: per-cycle strobe vectors per opcode,
// plus halt, async reset mid-store, and counter saturation on a narrow instance.
module tb_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  opcode = 8'h00;
   logic        zflag = 1'b0;

   logic        muxPC, muxMAR, muxACC, loadMAR, loadPC, loadACC, loadMDR, loadIR, memWE, halted;
   logic [1:0]  opALU;
   logic [15:0] instr_count;

   logic        s_muxPC, s_muxMAR, s_muxACC, s_loadMAR, s_loadPC, s_loadACC, s_loadMDR, s_loadIR;
   logic        s_memWE, s_halted;
   logic [1:0]  s_opALU;
   logic [1:0]  s_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic        illop, s_illop;
`endif

   ctrl_fsm #(.CNT_W(16), .HLT_OP(8'hFF)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zflag(zflag),
      .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC),
      .loadMAR(loadMAR), .loadPC(loadPC), .loadACC(loadACC), .loadMDR(loadMDR), .loadIR(loadIR),
      .opALU(opALU), .memWE(memWE), .halted(halted), .instr_count(instr_count)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .illop(illop)
`endif
   );

   ctrl_fsm #(.CNT_W(2), .HLT_OP(8'hFF)) dut_sat (
      .clk(clk), .rst(rst), .opcode(opcode), .zflag(zflag),
      .muxPC(s_muxPC), .muxMAR(s_muxMAR), .muxACC(s_muxACC),
      .loadMAR(s_loadMAR), .loadPC(s_loadPC), .loadACC(s_loadACC), .loadMDR(s_loadMDR),
      .loadIR(s_loadIR), .opALU(s_opALU), .memWE(s_memWE), .halted(s_halted),
      .instr_count(s_count)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .illop(s_illop)
`endif
   );

   always #5 clk = ~clk;

   // {muxPC,muxMAR,muxACC,loadMAR,loadPC,loadACC,loadMDR,loadIR,opALU[1:0],memWE,halted}
   logic [11:0] outv;
   assign outv = {muxPC, muxMAR, muxACC, loadMAR, loadPC, loadACC, loadMDR, loadIR,
                  opALU, memWE, halted};

   localparam logic [11:0] F0 = 12'h100, F1 = 12'h0A0, F2 = 12'h010;
   localparam logic [11:0] DMEM = 12'h500, MEM = 12'h020, HALTV = 12'h001;

   typedef struct {
      logic [7:0]  op;
      logic        z;
      int unsigned len;
      logic [11:0] exp [6];
   } row_t;

   row_t rows[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   task automatic add_row(input logic [7:0] op, input logic z, input int unsigned len,
                          input logic [11:0] e3, input logic [11:0] e4, input logic [11:0] e5);
      row_t r;
      r.op = op; r.z = z; r.len = len;
      r.exp[0] = F0; r.exp[1] = F1; r.exp[2] = F2;
      r.exp[3] = e3; r.exp[4] = e4; r.exp[5] = e5;
      rows.push_back(r);
   endtask

   task automatic chk_outs(input string name, input logic [11:0] exp);
      checks++;
      if (outv !== exp) begin
         errors++;
         $display("FAIL %s: outputs got %03h expected %03h", name, outv, exp);
      end
   endtask

   task automatic chk_val(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      add_row(8'h00, 1'b0, 4, 12'h000, 12'h000, 12'h000);  // NOP
      add_row(8'h01, 1'b0, 6, DMEM,    MEM,     12'h040);  // ADD
      add_row(8'h02, 1'b0, 6, DMEM,    MEM,     12'h044);  // SUB
      add_row(8'h03, 1'b0, 6, DMEM,    MEM,     12'h048);  // AND
      add_row(8'h04, 1'b0, 4, 12'h04C, 12'h000, 12'h000);  // NOT
      add_row(8'h05, 1'b0, 6, DMEM,    MEM,     12'h240);  // LDA
      add_row(8'h06, 1'b0, 5, DMEM,    12'h002, 12'h000);  // STA
      add_row(8'h07, 1'b0, 4, 12'h880, 12'h000, 12'h000);  // JMP
      add_row(8'h08, 1'b1, 4, 12'h880, 12'h000, 12'h000);  // JZ taken
      add_row(8'h08, 1'b0, 4, 12'h800, 12'h000, 12'h000);  // JZ not taken
`ifndef CTRL_ILLEGAL_TRAP_EN
      add_row(8'h3C, 1'b0, 4, 12'h000, 12'h000, 12'h000);  // undefined -> NOP
`endif

      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_outs("reset outputs", 12'h000);
      chk_val("reset count", int'(instr_count), 0);

      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_outs("idle after reset", 12'h000);

      foreach (rows[i]) begin
         for (int unsigned c = 0; c < rows[i].len; c++) begin
            @(negedge clk);
            chk_outs($sformatf("op%02h z%0d cycle%0d", rows[i].op, rows[i].z, c), rows[i].exp[c]);
            if (c == 0) begin
               chk_val($sformatf("count before op%02h", rows[i].op), int'(instr_count), exp_cnt);
               opcode = rows[i].op;
               zflag  = rows[i].z;
            end
         end
         exp_cnt++;
      end
      @(negedge clk);
      chk_outs("fetch0 after table", F0);
      chk_val("count after table", int'(instr_count), exp_cnt);
      chk_val("narrow counter saturates", int'(s_count), 3);

      opcode = 8'hFF;
      @(negedge clk); chk_outs("hlt fetch1", F1);
      @(negedge clk); chk_outs("hlt fetch2", F2);
      @(negedge clk); chk_outs("hlt decode", 12'h000);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk_outs($sformatf("halted cycle %0d", k), HALTV);
      end
      chk_val("count after hlt", int'(instr_count), exp_cnt + 1);

      #1 rst = 1'b0;
      #1 chk_outs("reset from halt", 12'h000);
      chk_val("count reset from halt", int'(instr_count), 0);

      @(posedge clk);
      #1 rst = 1'b1;
      opcode = 8'h06;
      @(negedge clk); chk_outs("sta idle", 12'h000);
      @(negedge clk); chk_outs("sta fetch0", F0);
      @(negedge clk); chk_outs("sta fetch1", F1);
      @(negedge clk); chk_outs("sta fetch2", F2);
      @(negedge clk); chk_outs("sta decode", DMEM);
      @(negedge clk); chk_outs("sta exec", 12'h002);
      #1 rst = 1'b0;
      #1 chk_outs("async reset drops memWE", 12'h000);
      chk_val("count after async reset", int'(instr_count), 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
      @(posedge clk);
      #1 rst = 1'b1;
      opcode = 8'h3C;
      @(negedge clk); chk_outs("trap idle", 12'h000);
      @(negedge clk); chk_outs("trap fetch0", F0);
      @(negedge clk); chk_outs("trap fetch1", F1);
      @(negedge clk); chk_outs("trap fetch2", F2);
      @(negedge clk); chk_outs("trap decode", 12'h000);
      @(negedge clk); chk_outs("trap halted", HALTV);
      chk_val("trap illop", int'(illop), 1);
      chk_val("trap count", int'(instr_count), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
